// File: rtl/atm_keypad_frontend.sv
// ---------------------------------------------------------------------------
// atm_keypad_frontend
//
// Collects one key event per cycle from the keypad scanner and assembles the
// account digit, PIN, operation, amount and new PIN for the ATM controller.
// Once a request is complete the fields are frozen, req_valid_o pulses for
// one cycle, and the block waits for session_done_i. An inactivity timer
// abandons partially entered sessions.
//
// Ports
//   clk_i           rising-edge clock
//   rst_ni          asynchronous active-low reset
//   key_valid_i     key_code_i is valid this cycle
//   key_code_i      0-9 digit, 0xA ENTER, 0xB CLEAR, 0xC CANCEL, 0xD-0xF ignored
//   session_done_i  controller finished the request (sampled in S_DONE only)
//   acc_num_o       account digit
//   pin_o           packed BCD PIN, first digit in [15:12]
//   new_pin_o       packed BCD new PIN, same ordering as pin_o
//   amount_o        binary value of the decimal amount
//   operation_o     1 BALANCE, 2 WITHDRAW, 3 DEPOSIT, 4 CHANGE_PIN
//   req_valid_o     one-cycle pulse in the first S_DONE cycle
//   busy_o          high in every phase except S_ACC
//   timeout_o       one-cycle pulse when the inactivity timer expires
//   phase_o         current state encoding
// ---------------------------------------------------------------------------
// state  | meaning
// S_ACC  | waiting for the account digit (idle)
// S_PIN  | collecting the 4-digit PIN
// S_OP   | waiting for a menu selection 1-4
// S_AMT  | collecting the decimal amount
// S_NPIN | collecting the 4-digit new PIN
// S_DONE | request presented, fields frozen until session_done_i
// ---------------------------------------------------------------------------
module atm_keypad_frontend #(
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    parameter int unsigned MAX_AMT_DIGITS = 8
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        key_valid_i,
    input  logic [3:0]  key_code_i,
    input  logic        session_done_i,
    output logic [3:0]  acc_num_o,
    output logic [15:0] pin_o,
    output logic [15:0] new_pin_o,
    output logic [31:0] amount_o,
    output logic [2:0]  operation_o,
    output logic        req_valid_o,
    output logic        busy_o,
    output logic        timeout_o,
    output logic [2:0]  phase_o
);

    localparam logic [2:0] S_ACC  = 3'd0;
    localparam logic [2:0] S_PIN  = 3'd1;
    localparam logic [2:0] S_OP   = 3'd2;
    localparam logic [2:0] S_AMT  = 3'd3;
    localparam logic [2:0] S_NPIN = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;

    localparam logic [3:0] K_ENTER  = 4'hA;
    localparam logic [3:0] K_CLEAR  = 4'hB;
    localparam logic [3:0] K_CANCEL = 4'hC;

    localparam int unsigned    TW         = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0]  TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]     AMT_MAX    = 4'(MAX_AMT_DIGITS);

    logic [2:0]    phase_q,    phase_d;
    logic [3:0]    acc_q,      acc_d;
    logic          acc_seen_q, acc_seen_d;
    logic [15:0]   pin_q,      pin_d;
    logic [2:0]    pin_cnt_q,  pin_cnt_d;
    logic [15:0]   npin_q,     npin_d;
    logic [2:0]    npin_cnt_q, npin_cnt_d;
    logic [31:0]   amt_q,      amt_d;
    logic [3:0]    amt_cnt_q,  amt_cnt_d;
    logic [2:0]    op_q,       op_d;
    logic          req_q,      req_d;
    logic [TW-1:0] timer_q,    timer_d;

    logic active;
    logic expire;
    logic is_digit;
    logic clear_all;

    // Timer only runs while a session is partially entered.
    assign active   = (phase_q == S_PIN) || (phase_q == S_OP) ||
                      (phase_q == S_AMT) || (phase_q == S_NPIN);
    // A key in the expiry cycle wins over the timeout.
    assign expire   = active && !key_valid_i && (timer_q == TIMER_LAST);
    assign is_digit = (key_code_i <= 4'd9);

    always_comb begin
        phase_d    = phase_q;
        acc_d      = acc_q;
        acc_seen_d = acc_seen_q;
        pin_d      = pin_q;
        pin_cnt_d  = pin_cnt_q;
        npin_d     = npin_q;
        npin_cnt_d = npin_cnt_q;
        amt_d      = amt_q;
        amt_cnt_d  = amt_cnt_q;
        op_d       = op_q;
        req_d      = 1'b0;
        clear_all  = expire;
        timer_d    = (key_valid_i || !active) ? '0 : timer_q + 1'b1;

        if (phase_q == S_DONE) begin
            if (session_done_i) begin
                clear_all = 1'b1;
            end
        end else if (key_valid_i) begin
            if (key_code_i == K_CANCEL) begin
                clear_all = 1'b1;
            end else if (key_code_i == K_CLEAR) begin
                case (phase_q)
                    S_ACC:  begin acc_d  = '0; acc_seen_d = 1'b0; end
                    S_PIN:  begin pin_d  = '0; pin_cnt_d  = '0;   end
                    S_OP:   op_d = '0;
                    S_AMT:  begin amt_d  = '0; amt_cnt_d  = '0;   end
                    S_NPIN: begin npin_d = '0; npin_cnt_d = '0;   end
                    default: ;
                endcase
            end else if (key_code_i == K_ENTER) begin
                case (phase_q)
                    S_ACC:  if (acc_seen_q) phase_d = S_PIN;
                    S_PIN:  if (pin_cnt_q == 3'd4) phase_d = S_OP;
                    S_OP: begin
                        case (op_q)
                            3'd1:       begin phase_d = S_DONE; req_d = 1'b1; end
                            3'd2, 3'd3: phase_d = S_AMT;
                            3'd4:       phase_d = S_NPIN;
                            default:    ;
                        endcase
                    end
                    S_AMT:  if (amt_cnt_q != 4'd0) begin
                                phase_d = S_DONE;
                                req_d   = 1'b1;
                            end
                    S_NPIN: if (npin_cnt_q == 3'd4) begin
                                phase_d = S_DONE;
                                req_d   = 1'b1;
                            end
                    default: ;
                endcase
            end else if (is_digit) begin
                case (phase_q)
                    S_ACC: begin
                        acc_d      = key_code_i;
                        acc_seen_d = 1'b1;
                    end
                    S_PIN: if (pin_cnt_q < 3'd4) begin
                        pin_d     = {pin_q[11:0], key_code_i};
                        pin_cnt_d = pin_cnt_q + 3'd1;
                    end
                    S_OP: begin
                        // Menu digit 5 is the on-screen cancel entry.
                        if (key_code_i == 4'd5) begin
                            clear_all = 1'b1;
                        end else if (key_code_i >= 4'd1 && key_code_i <= 4'd4) begin
                            op_d = key_code_i[2:0];
                        end
                    end
                    S_AMT: if (amt_cnt_q < AMT_MAX) begin
                        amt_d     = amt_q * 32'd10 + 32'(key_code_i);
                        amt_cnt_d = amt_cnt_q + 4'd1;
                    end
                    S_NPIN: if (npin_cnt_q < 3'd4) begin
                        npin_d     = {npin_q[11:0], key_code_i};
                        npin_cnt_d = npin_cnt_q + 3'd1;
                    end
                    default: ;
                endcase
            end
        end

        if (clear_all) begin
            phase_d    = S_ACC;
            acc_d      = '0;
            acc_seen_d = 1'b0;
            pin_d      = '0;
            pin_cnt_d  = '0;
            npin_d     = '0;
            npin_cnt_d = '0;
            amt_d      = '0;
            amt_cnt_d  = '0;
            op_d       = '0;
            req_d      = 1'b0;
            timer_d    = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            phase_q    <= S_ACC;
            acc_q      <= '0;
            acc_seen_q <= 1'b0;
            pin_q      <= '0;
            pin_cnt_q  <= '0;
            npin_q     <= '0;
            npin_cnt_q <= '0;
            amt_q      <= '0;
            amt_cnt_q  <= '0;
            op_q       <= '0;
            req_q      <= 1'b0;
            timer_q    <= '0;
        end else begin
            phase_q    <= phase_d;
            acc_q      <= acc_d;
            acc_seen_q <= acc_seen_d;
            pin_q      <= pin_d;
            pin_cnt_q  <= pin_cnt_d;
            npin_q     <= npin_d;
            npin_cnt_q <= npin_cnt_d;
            amt_q      <= amt_d;
            amt_cnt_q  <= amt_cnt_d;
            op_q       <= op_d;
            req_q      <= req_d;
            timer_q    <= timer_d;
        end
    end

    assign acc_num_o   = acc_q;
    assign pin_o       = pin_q;
    assign new_pin_o   = npin_q;
    assign amount_o    = amt_q;
    assign operation_o = op_q;
    assign req_valid_o = req_q;
    assign busy_o      = (phase_q != S_ACC);
    assign timeout_o   = expire;
    assign phase_o     = phase_q;

endmodule

// File: tb/tb_atm_keypad_frontend.sv
module tb_atm_keypad_frontend;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        key_valid = 1'b0;
    logic [3:0]  key_code = 4'h0;
    logic        session_done = 1'b0;
    logic [3:0]  acc_num_o;
    logic [15:0] pin_o;
    logic [15:0] new_pin_o;
    logic [31:0] amount_o;
    logic [2:0]  operation_o;
    logic        req_valid_o;
    logic        busy_o;
    logic        timeout_o;
    logic [2:0]  phase_o;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit          is_to;
        logic [3:0]  acc;
        logic [15:0] pin;
        logic [15:0] npin;
        logic [31:0] amt;
        logic [2:0]  op;
    } exp_t;

    exp_t exp_q[$];
    exp_t e_mon;
    logic prev_req = 1'b0;

    atm_keypad_frontend #(.TIMEOUT_CYCLES(20), .MAX_AMT_DIGITS(8)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .key_valid_i    (key_valid),
        .key_code_i     (key_code),
        .session_done_i (session_done),
        .acc_num_o      (acc_num_o),
        .pin_o          (pin_o),
        .new_pin_o      (new_pin_o),
        .amount_o       (amount_o),
        .operation_o    (operation_o),
        .req_valid_o    (req_valid_o),
        .busy_o         (busy_o),
        .timeout_o      (timeout_o),
        .phase_o        (phase_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    // Inputs change 1ns after the rising edge; one key occupies one cycle.
    task automatic press(input logic [3:0] c);
        @(posedge clk); #1;
        key_valid = 1'b1;
        key_code  = c;
        @(posedge clk); #1;
        key_valid = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic push_req(input logic [3:0] a, input logic [15:0] p, input logic [15:0] np,
                            input logic [31:0] amt, input logic [2:0] op);
        exp_t e;
        e.is_to = 1'b0; e.acc = a; e.pin = p; e.npin = np; e.amt = amt; e.op = op;
        exp_q.push_back(e);
    endtask

    task automatic push_to();
        exp_t e;
        e.is_to = 1'b1; e.acc = '0; e.pin = '0; e.npin = '0; e.amt = '0; e.op = '0;
        exp_q.push_back(e);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk(name, exp_q.size(), 0);
    endtask

    task automatic end_session();
        @(posedge clk); #1;
        session_done = 1'b1;
        @(posedge clk); #1;
        session_done = 1'b0;
        chk("sess_end_phase", phase_o, 0);
    endtask

    task automatic chk_cleared(input string name);
        chk({name, "_phase"}, phase_o, 0);
        chk({name, "_fields"}, {acc_num_o, pin_o, new_pin_o, operation_o}, 0);
        chk({name, "_amount"}, amount_o, 0);
        chk({name, "_flags"}, {busy_o, req_valid_o, timeout_o}, 0);
    endtask

    task automatic enter_to_op(input logic [3:0] a, input logic [15:0] p);
        press(a); press(4'hA);
        press(p[15:12]); press(p[11:8]); press(p[7:4]); press(p[3:0]);
        press(4'hA);
    endtask

    // Scoreboard monitor: pops one expectation per req_valid or timeout pulse.
    always @(negedge clk) begin
        if (rst_n) begin
            if (req_valid_o || timeout_o) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_event: req_valid=%0b timeout=%0b with empty queue",
                             req_valid_o, timeout_o);
                end else begin
                    e_mon = exp_q.pop_front();
                    chk("mon_kind", {31'b0, timeout_o}, {31'b0, e_mon.is_to});
                    if (!e_mon.is_to) begin
                        chk("mon_req_single", {31'b0, prev_req}, 0);
                        chk("mon_acc", acc_num_o, e_mon.acc);
                        chk("mon_pin", pin_o, e_mon.pin);
                        chk("mon_new_pin", new_pin_o, e_mon.npin);
                        chk("mon_amount", amount_o, e_mon.amt);
                        chk("mon_op", operation_o, e_mon.op);
                        chk("mon_phase", phase_o, 5);
                    end
                end
            end
            prev_req = req_valid_o;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        #23;
        chk_cleared("reset");
        rst_n = 1'b1;
        wait_cycles(2);

        // Balance request, then keys in S_DONE are ignored.
        press(4'hA);
        chk("acc_enter_empty", phase_o, 0);
        enter_to_op(4'd3, 16'h1234);
        chk("to_op_phase", phase_o, 2);
        press(4'd1);
        push_req(4'd3, 16'h1234, 16'h0, 32'd0, 3'd1);
        press(4'hA);
        wait_drain("drain_balance");
        press(4'd7);
        chk("done_frozen_acc", acc_num_o, 3);
        chk("done_busy", busy_o, 1);
        end_session();
        chk_cleared("after_balance");

        // Withdraw 250, session_done in the req_valid cycle.
        enter_to_op(4'd5, 16'h1111);
        press(4'd2); press(4'hA);
        chk("amt_phase", phase_o, 3);
        press(4'd2); press(4'd5); press(4'd0);
        push_req(4'd5, 16'h1111, 16'h0, 32'd250, 3'd2);
        press(4'hA);
        session_done = 1'b1;
        @(posedge clk); #1;
        session_done = 1'b0;
        chk_cleared("same_cycle_done");
        wait_drain("drain_withdraw");

        // Short PIN, PIN saturation, change-PIN request.
        press(4'd1); press(4'hA);
        press(4'd1); press(4'd2); press(4'd3); press(4'hA);
        chk("short_pin_phase", phase_o, 1);
        press(4'd4); press(4'd9);
        chk("pin_saturate", pin_o, 16'h1234);
        press(4'hA);
        chk("pin_to_op", phase_o, 2);
        press(4'd4); press(4'hA);
        chk("npin_phase", phase_o, 4);
        press(4'd9); press(4'd8); press(4'd7); press(4'd6);
        push_req(4'd1, 16'h1234, 16'h9876, 32'd0, 3'd4);
        press(4'hA);
        wait_drain("drain_chpin");
        end_session();

        // Deposit: CLEAR in S_AMT, then amount saturates at 8 digits.
        enter_to_op(4'd2, 16'h5555);
        press(4'd3); press(4'hA);
        press(4'd5); press(4'd5);
        chk("amt_55", amount_o, 55);
        press(4'hB);
        chk("amt_clear", amount_o, 0);
        chk("amt_clear_phase", phase_o, 3);
        for (int i = 0; i < 9; i++) press(4'd9);
        chk("amt_saturate", amount_o, 32'd99999999);
        push_req(4'd2, 16'h5555, 16'h0, 32'd99999999, 3'd3);
        press(4'hA);
        wait_drain("drain_deposit");
        end_session();

        // S_OP selection rules, digit 5 cancels.
        enter_to_op(4'd7, 16'h0000);
        press(4'hA);
        chk("op_enter_empty", phase_o, 2);
        press(4'd0); press(4'd9); press(4'hE);
        chk("op_ignored", operation_o, 0);
        press(4'd3); press(4'hB);
        chk("op_clear", operation_o, 0);
        press(4'd5);
        chk_cleared("op_digit5_cancel");

        // CANCEL key in S_OP.
        enter_to_op(4'd7, 16'h1234);
        press(4'd2); press(4'hC);
        chk_cleared("op_cancel");

        // Timeout 20 cycles after the last key.
        press(4'd4); press(4'hA); press(4'd1); press(4'd2);
        chk("to_pin", pin_o, 16'h0012);
        push_to();
        k = 0;
        while (!timeout_o && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        chk("timeout_delay", k, 19);
        @(posedge clk); #1;
        chk_cleared("after_timeout");
        wait_drain("drain_timeout");

        // Key at cycle 19, then a key exactly in the expiry cycle.
        press(4'd4); press(4'hA); press(4'd1); press(4'd2);
        wait_cycles(17);
        press(4'd3);
        chk("late_key_phase", phase_o, 1);
        wait_cycles(18);
        press(4'd4);
        chk("expiry_key_phase", phase_o, 1);
        chk("expiry_key_pin", pin_o, 16'h1234);

        // Async reset mid S_NPIN.
        press(4'hA); press(4'd4); press(4'hA); press(4'd6); press(4'd6);
        chk("pre_reset_npin", new_pin_o, 16'h0066);
        #3;
        rst_n = 1'b0;
        #1;
        chk_cleared("async_reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        wait_cycles(3);
        chk("final_queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/atm_keypad_frontend.md
# atm_keypad_frontend

Keypad front end sitting directly upstream of the ATM controller. It takes one key event per cycle from the keypad scanner and assembles the account number, PIN, operation, amount and new PIN that the controller consumes. When the request is complete it holds these fields stable, issues a one-cycle `req_valid` strobe, and waits for the controller's `session_done`. An inactivity timer abandons partially entered sessions.

## Interface
- `TIMEOUT_CYCLES`, 1000: idle cycles between keys before the session is abandoned (≥2).
- `MAX_AMT_DIGITS`, 8: maximum decimal digits accepted for the amount (≤9).
- `clk` in 1: the single clock; all state is on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `key_valid` in 1: `key_code` is valid this cycle (single-cycle strobe from the scanner).
- `key_code` in 4: 0–9 digit; 0xA ENTER; 0xB CLEAR; 0xC CANCEL; 0xD–0xF ignored.
- `session_done` in 1: controller has finished the request.
- `acc_num` out 4: account digit.
- `pin` out 16: packed BCD; first digit in [15:12].
- `new_pin` out 16: packed BCD; same ordering as `pin`.
- `amount` out 32: binary value of the entered decimal amount.
- `operation` out 3: menu digit 1–4 (BALANCE=1, WITHDRAW=2, DEPOSIT=3, CHANGE_PIN=4, per definitions.v).
- `req_valid` out 1: one-cycle pulse on entry to the DONE phase.
- `busy` out 1: high in every phase except S_ACC.
- `timeout` out 1: one-cycle pulse when the inactivity timer expires.
- `phase` out 3: current state encoding.

## Operation
- States and encodings: S_ACC=0, S_PIN=1, S_OP=2, S_AMT=3, S_NPIN=4, S_DONE=5.
- Only cycles with `key_valid`=1 are examined. Codes 0xD–0xF are dropped, but they still restart the timer.
- **S_ACC**
  - A digit loads `acc_num`; a later digit overwrites it.
  - ENTER after at least one digit → S_PIN.
  - ENTER with no digit is ignored.
- **S_PIN**
  - Digits shift in: `pin` = {`pin`[11:0], d}. Digit count saturates at 4; a 5th digit is ignored.
  - ENTER with exactly 4 digits → S_OP. ENTER with fewer than 4 is ignored.
- **S_OP**
  - Digits 1–4 set `operation`. Digit 5 acts as CANCEL. Digits 0 and 6–9 are ignored.
  - ENTER with `operation`=1 → S_DONE.
  - ENTER with `operation`=2 or 3 → S_AMT.
  - ENTER with `operation`=4 → S_NPIN.
  - ENTER with no operation selected is ignored.
- **S_AMT**
  - Digits accumulate: `amount` = `amount`×10 + d, computed in 32 bits.
  - After `MAX_AMT_DIGITS` digits, further digits are ignored. 8 digits (max 99,999,999) cannot overflow.
  - ENTER with at least one digit → S_DONE. A value of 0 is allowed; the controller rejects it.
- **S_NPIN**
  - Same shift and count rules as S_PIN, writing `new_pin`.
  - ENTER with 4 digits → S_DONE.
- **CLEAR**: clears only the field of the current phase and its digit count. It does not change state.
  - S_OP: clears `operation`.
  - S_ACC: clears `acc_num` to 0.
- **CANCEL** in any phase except S_DONE → S_ACC. All fields, counters and the timer are cleared.
- **S_DONE**
  - Fields are frozen and keys are ignored.
  - `session_done`=1 → S_ACC with all fields cleared.
- **Timer**
  - Counts cycles in S_PIN through S_NPIN. It restarts to 0 on any `key_valid`.
  - On reaching `TIMEOUT_CYCLES`−1: `timeout` pulses, then the same clearing as CANCEL is applied.
  - The timer is held at 0 in S_ACC and S_DONE.

## Timing
- Reset values: every output is 0, `phase`=S_ACC, timer=0, and all digit counts are 0.
- The key is registered on the clock edge where it is sampled. Fields and `phase` update on that edge and are visible the next cycle.
- `req_valid` is high exactly in the first cycle with `phase`=S_DONE. All fields are stable from that cycle until S_DONE exits.
- `session_done` is sampled only in S_DONE. S_ACC and cleared fields are visible one cycle later.
  - `session_done` in the same cycle as `req_valid` is honoured.
- Simultaneous events:
  - `key_valid` in the same cycle as timer expiry: the key wins, the timer restarts and `timeout` is not pulsed.
  - CANCEL and ENTER cannot collide, since there is one key per cycle.
- Reset asserted mid-entry clears everything immediately, with no `req_valid` and no `timeout`.

## Test plan
- Account 3, PIN 1,2,3,4, op 1, with ENTER after each field → `req_valid` one cycle; `acc_num`=3, `pin`=0x1234, `operation`=1, `amount`=0.
- Op 2, digits 2,5,0, ENTER → `amount`=250 at `req_valid`. Then `session_done` → next cycle `phase`=0 and all fields 0.
- PIN 1,2,3 then ENTER → still S_PIN. Digits 4,9 → `pin`=0x1234 (the 9 is dropped). ENTER → S_OP.
- Op 4, new PIN 9,8,7,6, ENTER → `new_pin`=0x9876, `operation`=4, `req_valid`. In S_AMT, 9 digits of 9 → `amount`=99,999,999.
- With `TIMEOUT_CYCLES`=20: stop in S_PIN after 2 digits → `timeout` pulses 20 cycles after the last key, `phase`=0, `pin`=0. A key at cycle 19 → no timeout.
- CLEAR in S_AMT after 5,5 → `amount`=0, still S_AMT. CANCEL in S_OP → S_ACC. `rst` low mid-S_NPIN → all outputs 0 asynchronously.
